// File: rtl/filter_mode_ctrl.sv
`timescale 1ns/1ps
// filter_mode_ctrl
// Front-panel controller for the 5x5 convolution filter stage. It debounces
// three push-buttons and holds a pending filter mode and edge threshold. Both
// are committed together at the next frame start, so a frame never mixes
// settings. It also selects which filter output is passed to the pixel path.
//
// Ports:
//   clk, rst           pixel clock, synchronous active-high reset
//   btn_mode/up/down   raw asynchronous push-buttons, active-high
//   x_pixel, y_pixel   current raster position
//   disp_enable        active video
//   gray_in            unfiltered grayscale pixel
//   *_in               filter outputs (sobel, gaussian, average, laplacian)
//   threshold          committed edge threshold to the filter
//   mode               committed mode (0 bypass, 1 gauss, 2 avg, 3 sobel, 4 lap)
//   mode_pending       pending settings differ from the committed ones
//   pixel_out          selected pixel, one cycle of latency
module filter_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter logic [7:0]  THR_DEFAULT     = 8'd64,
    parameter logic [7:0]  THR_STEP        = 8'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [9:0] x_pixel,
    input  logic [9:0] y_pixel,
    input  logic       disp_enable,
    input  logic [7:0] gray_in,
    input  logic [7:0] sobel_in,
    input  logic [7:0] gaussian_in,
    input  logic [7:0] average_in,
    input  logic [7:0] laplacian_in,
    output logic [7:0] threshold,
    output logic [2:0] mode,
    output logic       mode_pending,
    output logic [7:0] pixel_out
);

    localparam int unsigned NUM_BTN  = 3;
    localparam int unsigned BTN_MODE = 0;
    localparam int unsigned BTN_UP   = 1;
    localparam int unsigned BTN_DOWN = 2;
    localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES);

    // The counter only needs to reach DEBOUNCE_CYCLES-1: the accepting edge
    // is the one on which it would reach DEBOUNCE_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] MODE_BYPASS    = 3'd0;
    localparam logic [2:0] MODE_GAUSSIAN  = 3'd1;
    localparam logic [2:0] MODE_AVERAGE   = 3'd2;
    localparam logic [2:0] MODE_SOBEL     = 3'd3;
    localparam logic [2:0] MODE_LAPLACIAN = 3'd4;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic [NUM_BTN-1:0] db;
    logic [NUM_BTN-1:0] press;
    logic [CNT_W-1:0]   db_cnt [NUM_BTN];

    logic [2:0] pend_mode;
    logic [7:0] pend_thr;
    logic [8:0] thr_sum_c;
    logic [7:0] thr_inc_c;
    logic [7:0] thr_dec_c;

    logic   frame_start_c;
    logic   differ_c;
    logic   commit_c;
    state_t state;
    state_t state_nxt;

    logic [7:0] pix_sel_c;

    assign btn_raw = {btn_down, btn_up, btn_mode};

    // Synchronize, debounce, and emit a one-cycle pulse on each accepted press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            press <= '0;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    db_cnt[i] <= '0;
                    db[i]     <= sync2[i];
                    press[i]  <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Saturating threshold step, computed one bit wider to catch overflow.
    always_comb begin
        thr_sum_c = {1'b0, pend_thr} + {1'b0, THR_STEP};
        thr_inc_c = thr_sum_c[8] ? 8'hFF : thr_sum_c[7:0];
        thr_dec_c = (pend_thr < THR_STEP) ? 8'h00 : (pend_thr - THR_STEP);
    end

    // Pending settings; opposing up/down presses in one cycle cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_mode <= MODE_BYPASS;
            pend_thr  <= THR_DEFAULT;
        end else begin
            if (press[BTN_MODE]) begin
                pend_mode <= (pend_mode == MODE_LAPLACIAN) ? MODE_BYPASS
                                                           : pend_mode + 3'd1;
            end
            if (press[BTN_UP] && !press[BTN_DOWN]) begin
                pend_thr <= thr_inc_c;
            end else if (press[BTN_DOWN] && !press[BTN_UP]) begin
                pend_thr <= thr_dec_c;
            end
        end
    end

    assign frame_start_c = disp_enable && (x_pixel == 10'd0) && (y_pixel == 10'd0);
    assign differ_c      = (pend_mode != mode) || (pend_thr != threshold);

    // Commit FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Commit FSM next state; a commit always takes the pending value present
    // before this edge, so a coincident press re-arms on the following cycle.
    always_comb begin
        state_nxt = state;
        commit_c  = 1'b0;
        case (state)
            IDLE: begin
                if (differ_c) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (frame_start_c) begin
                    commit_c  = 1'b1;
                    state_nxt = IDLE;
                end else if (!differ_c) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mode_pending = (state == ARMED);

    // Committed settings.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode      <= MODE_BYPASS;
            threshold <= THR_DEFAULT;
        end else if (commit_c) begin
            mode      <= pend_mode;
            threshold <= pend_thr;
        end
    end

    // Output source select; unreachable codes fall back to bypass.
    always_comb begin
        pix_sel_c = gray_in;
        case (mode)
            MODE_GAUSSIAN:  pix_sel_c = gaussian_in;
            MODE_AVERAGE:   pix_sel_c = average_in;
            MODE_SOBEL:     pix_sel_c = sobel_in;
            MODE_LAPLACIAN: pix_sel_c = laplacian_in;
            default:        pix_sel_c = gray_in;
        endcase
    end

    // Single register stage for every mode keeps downstream alignment fixed.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_out <= 8'h00;
        end else begin
            pixel_out <= disp_enable ? pix_sel_c : 8'h00;
        end
    end

endmodule
